// File: rtl/vack_pkg.sv
// Shared constants for the valid/ack receive buffer: default sizing and input FSM encoding.
package vack_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACK  = 1'b1;

endpackage

// File: rtl/vack_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; synchronous active-low reset.
module vack_sync_fifo
  import vack_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Both qualifiers use pre-edge occupancy: no push-through-pop when full, no bypass when empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vack_rx_buffer.sv
// Receiver for the 4-phase valid/ack sender, buffering words onto a valid/ready stream.
// Optional VACK_RX_STATS_EN adds a 16-bit accepted-word counter port rx_words.
module vack_rx_buffer
  import vack_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef VACK_RX_STATS_EN
  output logic [15:0]       rx_words,
`endif
  output logic [CNT_W-1:0]  count
);

  logic state_q, state_d;
  logic push;
  logic full;
  logic empty;

  // One word per 4-phase cycle: only IDLE may push, and only when a slot is free.
  assign push = (state_q == ST_IDLE) && in_valid && !full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (push)      state_d = ST_ACK;
      ST_ACK:  if (!in_valid) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign in_ack    = (state_q == ST_ACK);
  assign out_valid = !empty;

  vack_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (in_data),
    .pop   (out_ready),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef VACK_RX_STATS_EN
  logic [15:0] rx_words_q;

  always_ff @(posedge clk) begin
    if (!rstn)     rx_words_q <= '0;
    else if (push) rx_words_q <= rx_words_q + 16'd1;
  end

  assign rx_words = rx_words_q;
`endif

endmodule

// File: tb/tb_vack_rx_buffer.sv
// Directed self-checking bench for vack_rx_buffer (DATA_W=8, DEPTH=4).
module tb_vack_rx_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
`ifdef VACK_RX_STATS_EN
  logic [15:0]       rx_words;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vack_rx_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef VACK_RX_STATS_EN
    .rx_words  (rx_words),
`endif
    .count     (count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", in_ack); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA1;
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pre got=%b exp=0", in_ack); end
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL single_ack_rise got=%b exp=1", in_ack); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA1) begin errors++; $display("FAIL single_out_data got=%h exp=a1", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    in_valid = 1'b0;
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL single_ack_fall got=%b exp=0", in_ack); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_stream();
    logic [7:0] words [4];
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hD8; words[3] = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL stream_ack[%0d] got=%b exp=1", i, in_ack); end
      checks++; if (out_data !== words[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, words[i]); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
      in_valid = 1'b0;
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_popped[%0d] got=%0d exp=0", i, count); end
      checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL stream_ack_fall[%0d] got=%b exp=0", i, in_ack); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] words [4];
    logic [7:0] drain [4];
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hD8; words[3] = 8'hFF;
    drain[0] = 8'hB2; drain[1] = 8'hD8; drain[2] = 8'hFF; drain[3] = 8'hC9;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL full_ack[%0d] got=%b exp=1", i, in_ack); end
      in_valid = 1'b0;
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    in_valid = 1'b1; in_data = 8'hC9;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL full_backpressure got=%b exp=0", in_ack); end
    checks++; if (out_data !== 8'hA1) begin errors++; $display("FAIL full_head got=%h exp=a1", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL full_no_pushthrough got=%b exp=0", in_ack); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL full_late_ack got=%b exp=1", in_ack); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refill_count got=%0d exp=4", count); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== drain[i]) begin errors++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, out_data, drain[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_hold_valid();
    in_valid = 1'b1; in_data = 8'h3C;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL hold_ack got=%b exp=1", in_ack); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", count); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL hold_drain got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h22;
    tick();
    checks++; if (in_ack !== 1'b1 || count !== 3'd2) begin
      errors++; $display("FAIL midrst_setup ack=%b count=%0d exp ack=1 count=2", in_ack, count);
    end
    rstn = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0", in_ack); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    rstn = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL midrst_new_ack got=%b exp=1", in_ack); end
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL midrst_new_data got=%h exp=5a", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_new_count got=%0d exp=1", count); end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef VACK_RX_STATS_EN
  task automatic test_stats();
    // Only the 0x5A handshake has been accepted since the last reset.
    checks++; if (rx_words !== 16'd1) begin errors++; $display("FAIL stats_after_reset got=%0d exp=1", rx_words); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (rx_words !== 16'd4) begin errors++; $display("FAIL stats_count got=%0d exp=4", rx_words); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_hold_valid();
    test_reset_mid();
`ifdef VACK_RX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vack_rx_buffer.md
Name: vack_rx_buffer

Overview:
- Receiver stage directly downstream of the valid/ack FSM handshake sender.
- Completes the 4-phase valid/ack protocol on its input side and captures each transferred byte into a small synchronous FIFO.
- Presents the buffered words on a valid/ready stream to the next consumer, decoupling sender rate from consumer rate.

Parameters:
- DATA_W, 8, width of the transferred data word.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  sender valid (4-phase request).
- in_data  input  DATA_W  sender data; stable while in_valid=1.
- in_ack  output  1  acknowledge to sender; registered.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer ready.
- out_data  output  DATA_W  head-of-FIFO word (show-ahead).
- count  output  CNT_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; in_ack=0; wr_ptr=rd_ptr=0; count=0; out_valid=0.
  - out_data reads mem[0], whose value is don't-care; memory contents are not cleared.
  - Reset mid-handshake aborts the transfer. Any word already written stays lost because pointers are cleared. The sender must restart.
- Input FSM, two states:
  - IDLE (in_ack=0): at an edge with in_valid=1 and full=0, write in_data to mem[wr_ptr], increment wr_ptr, go to ACK. in_ack becomes 1 on that same edge, so it is visible 1 cycle after valid is sampled.
  - IDLE with in_valid=1 and full=1: stay in IDLE with no write. The sender is back-pressured simply by in_ack staying 0.
  - ACK (in_ack=1): hold until in_valid=0 is sampled, then go to IDLE with in_ack=0 on that edge.
  - No second write can occur while in ACK, even if in_valid stays high: exactly one word per 4-phase cycle.
  - Minimum handshake period: 4 clk cycles.
- Output side:
  - out_valid = (count != 0), combinational from registered count.
  - out_data = mem[rd_ptr].
  - Pop when out_valid && out_ready: rd_ptr increments at the edge.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- full = (count == DEPTH).
- count update rule: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
- Simultaneous push and pop:
  - Allowed whenever full=0 at the start of the cycle.
  - Full is judged on pre-edge count: no push-through-pop when full. A pop while full frees a slot, and the push is accepted on the following cycle.
- Simultaneous push and pop when count=0: no bypass. The word appears on out_data one cycle after the write.
- out_ready while out_valid=0 is ignored; the pointer does not move.
- out_data is held stable while out_valid=1 and out_ready=0.

Optional Feature:
- VACK_RX_STATS_EN defined:
  - Adds output port rx_words [15:0], which increments on every accepted push and wraps from 0xFFFF to 0.
  - Reset to 0 by rstn.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package vack_pkg holds:
  - State encoding constants ST_IDLE=1'b0 and ST_ACK=1'b1.
  - Default DATA_W and DEPTH values.
- Natural sub-module: vack_sync_fifo (mem, pointers, count, full/empty).
  - Instantiated by vack_rx_buffer.
  - The input FSM and the stats counter stay in the top.

Test Plan:
- Reset, then a single handshake with in_data=0xA1:
  - in_ack rises 1 cycle after in_valid is sampled.
  - Sender drops valid; in_ack falls on the next edge.
  - out_valid=1 and out_data=0xA1 one cycle after the write; count=1.
- Sequence 0xA1, 0xB2, 0xD8, 0xFF with out_ready=1 throughout:
  - Words emerge in order, each with a single out_valid&&out_ready beat.
  - count never exceeds 1.
- out_ready=0 and 5 handshakes (0xA1, 0xB2, 0xD8, 0xFF, 0xC9), DEPTH=4:
  - First 4 acked; count=4.
  - 5th holds in_ack=0 indefinitely.
  - Raise out_ready for 1 cycle: 0xA1 pops; next cycle 0xC9 is written and acked; count=4.
- in_valid held high for 10 cycles:
  - Exactly one write; in_ack stays 1; count=1.
- Assert rstn=0 while in ACK with count=2:
  - Next edge: in_ack=0, count=0, out_valid=0.
  - A new handshake with 0x5A is then accepted normally.
- With VACK_RX_STATS_EN defined:
  - 70000 accepted handshakes (or force the counter to 0xFFFE, then do 3) show rx_words wrapping: 0xFFFE, 0xFFFF, 0x0000, 0x0001.
